framing_encoding_param: RTL and testbench
=========================================

FRAMING_ENCODING_PARAM -- requirements
Module: framing_encoding_param

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- SYMBOL_BITS, 1, bits emitted per clock; legal 1, 2, 4, 8.
- PREAMBLE_BYTES, 4, count of 0x00 preamble octets; legal 1..15.
- SFD_VALUE, 8'hA7, start-of-frame delimiter octet.
- APPEND_FCS, 0, 1 = block computes and appends 2-octet FCS.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- phr_psdu_in, in, 8, PHR octet (first of frame) then PSDU octets.
- phr_psdu_in_valid, in, 1, upstream octet valid.
- phr_psdu_in_ready, out, 1, block accepts octet; transfer on valid&ready.
- framing_encoding_out, out, SYMBOL_BITS, serial symbol; bit 0 earliest in time.
- framing_encoding_out_valid, out, 1, symbol valid.
- frame_busy, out, 1, high from PHR accept until return to IDLE.
- frame_error, out, 1, one-cycle pulse on underrun or illegal length.

Function
REQ-003 The block SHALL use states IDLE, PREAMBLE, SFD, PHR, PSDU, FCS.
REQ-004 In IDLE, ready SHALL be 1; the first accepted octet SHALL be latched as the PHR, and L = PHR[6:0].
REQ-005 The first preamble symbol SHALL appear with out_valid=1 on the cycle after PHR acceptance; 1-cycle latency.
REQ-006 Frame order SHALL be PREAMBLE_BYTES x 0x00, SFD_VALUE, PHR unchanged, then L PSDU octets; if APPEND_FCS=1, the L octets comprise L-2 upstream octets followed by 2 FCS octets.
REQ-007 Each octet SHALL be sent LSB-first, SYMBOL_BITS per cycle, in 8/SYMBOL_BITS cycles; the lowest unsent bits SHALL occupy out[0] upward.
REQ-008 out_valid SHALL be continuously high for (PREAMBLE_BYTES+2+L)*8/SYMBOL_BITS cycles, with no gaps.
REQ-009 The block SHALL hold a single-octet holding register; ready=1 in PREAMBLE/SFD/PHR/PSDU only while that register is empty and upstream octets remain to be fetched; otherwise 0.
REQ-010 Each PSDU octet SHALL be accepted no later than the cycle carrying the last symbol of the preceding octet.
REQ-011 If an octet is not available as required by REQ-010, the next cycle SHALL carry an underrun response: out_valid=0, frame_error=1 for one cycle, state IDLE, partial frame abandoned.
REQ-012 FCS SHALL be CRC-16, G = x^16+x^12+x^5+1, init 0x0000, bits fed LSB-first over the upstream PSDU octets only (PHR excluded); FCS register bit r0 is sent first.
REQ-013 If APPEND_FCS=1 and L<2, the block SHALL emit no symbols, pulse frame_error for one cycle on the cycle after PHR acceptance, and return to IDLE.
REQ-014 If L=0 and APPEND_FCS=0, the frame SHALL end after the PHR.
REQ-015 After the last symbol, the block SHALL spend at least one cycle in IDLE with out_valid=0 and frame_busy=0 before the next frame's symbols.
REQ-016 framing_encoding_out SHALL be 0 whenever out_valid=0.
REQ-017 Upstream octets offered while ready=0 SHALL be ignored and not consumed.

Reset
REQ-018 reset_n low SHALL immediately force: state IDLE; all outputs 0 except phr_psdu_in_ready; holding register empty; CRC cleared.
REQ-019 phr_psdu_in_ready SHALL be 0 while reset_n is low and 1 on the first clock edge after release.
REQ-020 Reset asserted mid-frame SHALL abort the frame without a frame_error pulse; the next PHR SHALL start a full frame including the preamble.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- V1 SYMBOL_BITS=1, PREAMBLE_BYTES=4, APPEND_FCS=0; PHR 0x03 then 0x01, 0x05, 0x21 offered back-to-back -> out_valid high 72 contiguous cycles starting the cycle after PHR accept. Bits: 32 zeros, 1,1,1,0,0,1,0,1 (0xA7), 1,1,0,0,0,0,0,0 (0x03), then the PSDU LSB-first.
- V2 Same frame with SYMBOL_BITS=4 -> 18 cycles, nibbles 0 x8, 7, A, 3, 0, 1, 0, 5, 0, 1, 2.
- V3 Underrun: PHR 0x03, one PSDU octet, then valid held 0 -> out_valid drops on the cycle the second PSDU octet would start; frame_error pulses once; ready=1 the following cycle.
- V4 APPEND_FCS=1, SYMBOL_BITS=1; PHR 0x04, PSDU 0x40, 0x00 -> exactly 2 upstream octets accepted; 80 symbol cycles; last 16 bits match the REQ-012 CRC model.
- V5 APPEND_FCS=1, PHR 0x01 -> no out_valid; frame_error pulse on the cycle after accept; IDLE.
- V6 reset_n pulsed low for 20 time units mid-PSDU -> outputs 0 asynchronously; the next PHR produces a complete frame with the full preamble.

Source files
------------

// File: rtl/framing_encoding_param.sv
// rtl/framing_encoding_param.sv - PHR/PSDU octet stream to serial symbols with preamble, SFD and optional CRC-16 FCS
module framing_encoding_param #(
    parameter int         SYMBOL_BITS    = 1,
    parameter int         PREAMBLE_BYTES = 4,
    parameter logic [7:0] SFD_VALUE      = 8'hA7,
    parameter bit         APPEND_FCS     = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             phr_psdu_in,
    input  logic                   phr_psdu_in_valid,
    output logic                   phr_psdu_in_ready,
    output logic [SYMBOL_BITS-1:0] framing_encoding_out,
    output logic                   framing_encoding_out_valid,
    output logic                   frame_busy,
    output logic                   frame_error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_PHR  = 3'd3;
    localparam logic [2:0] S_PSDU = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;

    localparam int         SPO      = 8 / SYMBOL_BITS;
    localparam logic [2:0] SYM_LAST = 3'(SPO - 1);
    localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_BYTES - 1);

    logic [2:0]  state;
    logic [7:0]  phr_reg;
    logic [7:0]  hold_reg;
    logic        hold_full;
    logic [7:0]  shift_reg;
    logic [2:0]  sym_cnt;
    logic [6:0]  byte_cnt;
    logic [6:0]  up_len;
    logic [6:0]  fetch_rem;
    logic [15:0] crc;
    logic        ready_en;
    logic        error_q;

    logic        sending;
    logic        accept;
    logic        boundary;
    logic        next_avail;
    logic [7:0]  next_up;
    logic        up_done;
    logic        take_up;

    // Reflected form of G = x^16+x^12+x^5+1; bit 0 of the register is transmitted first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ 16'h8408;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    assign sending    = (state != S_IDLE);
    assign phr_psdu_in_ready = ready_en && (!sending || (!hold_full && (fetch_rem != 7'd0)));
    assign accept     = phr_psdu_in_valid && phr_psdu_in_ready;
    assign boundary   = sending && (sym_cnt == SYM_LAST);
    // An octet accepted on the boundary cycle bypasses the holding register.
    assign next_avail = hold_full || accept;
    assign next_up    = hold_full ? hold_reg : phr_psdu_in;
    assign up_done    = (state == S_PHR) ? (up_len == 7'd0) : (byte_cnt == up_len - 7'd1);
    assign take_up    = boundary && ((state == S_PHR) || (state == S_PSDU)) && !up_done && next_avail;

    assign framing_encoding_out_valid = sending;
    assign framing_encoding_out       = sending ? shift_reg[SYMBOL_BITS-1:0] : '0;
    assign frame_busy                 = sending;
    assign frame_error                = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            phr_reg   <= 8'h00;
            hold_reg  <= 8'h00;
            hold_full <= 1'b0;
            shift_reg <= 8'h00;
            sym_cnt   <= 3'd0;
            byte_cnt  <= 7'd0;
            up_len    <= 7'd0;
            fetch_rem <= 7'd0;
            crc       <= 16'h0000;
            ready_en  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            error_q  <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    phr_reg   <= phr_psdu_in;
                    crc       <= 16'h0000;
                    hold_full <= 1'b0;
                    shift_reg <= 8'h00;
                    sym_cnt   <= 3'd0;
                    byte_cnt  <= 7'd0;
                    if (APPEND_FCS && (phr_psdu_in[6:0] < 7'd2)) begin
                        error_q <= 1'b1;
                    end else begin
                        state     <= S_PRE;
                        up_len    <= APPEND_FCS ? (phr_psdu_in[6:0] - 7'd2) : phr_psdu_in[6:0];
                        fetch_rem <= APPEND_FCS ? (phr_psdu_in[6:0] - 7'd2) : phr_psdu_in[6:0];
                    end
                end
            end else begin
                if (accept) begin
                    fetch_rem <= fetch_rem - 7'd1;
                end
                if (accept && !take_up) begin
                    hold_reg  <= phr_psdu_in;
                    hold_full <= 1'b1;
                end
                if (!boundary) begin
                    sym_cnt   <= sym_cnt + 3'd1;
                    shift_reg <= shift_reg >> SYMBOL_BITS;
                end else begin
                    sym_cnt <= 3'd0;
                    case (state)
                        S_PRE: begin
                            if (byte_cnt == PRE_LAST) begin
                                state     <= S_SFD;
                                shift_reg <= SFD_VALUE;
                            end else begin
                                byte_cnt  <= byte_cnt + 7'd1;
                                shift_reg <= 8'h00;
                            end
                        end
                        S_SFD: begin
                            state     <= S_PHR;
                            shift_reg <= phr_reg;
                        end
                        S_PHR, S_PSDU: begin
                            if (up_done) begin
                                if (APPEND_FCS) begin
                                    state     <= S_FCS;
                                    shift_reg <= crc[7:0];
                                    byte_cnt  <= 7'd0;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else if (next_avail) begin
                                state     <= S_PSDU;
                                shift_reg <= next_up;
                                hold_full <= 1'b0;
                                crc       <= crc16_byte(crc, next_up);
                                byte_cnt  <= (state == S_PHR) ? 7'd0 : (byte_cnt + 7'd1);
                            end else begin
                                // Underrun: abandon the partial frame.
                                state   <= S_IDLE;
                                error_q <= 1'b1;
                            end
                        end
                        S_FCS: begin
                            if (byte_cnt == 7'd0) begin
                                shift_reg <= crc[15:8];
                                byte_cnt  <= 7'd1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_framing_encoding_param.sv
// tb/tb_framing_encoding_param.sv - self-checking bench for framing_encoding_param
module tb_framing_encoding_param;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din  [3];
    logic       dval [3];
    wire        rdy  [3];
    wire        ov   [3];
    wire        busy [3];
    wire        ferr [3];
    wire [0:0]  out_a;
    wire [3:0]  out_b;
    wire [0:0]  out_c;
    wire [7:0]  dout [3];

    assign dout[0] = {7'b0, out_a};
    assign dout[1] = {4'b0, out_b};
    assign dout[2] = {7'b0, out_c};

    always #5 clk = ~clk;

    framing_encoding_param #(.SYMBOL_BITS(1), .PREAMBLE_BYTES(4), .SFD_VALUE(8'hA7), .APPEND_FCS(1'b0)) dut_a (
        .clk(clk), .reset_n(rstn), .phr_psdu_in(din[0]), .phr_psdu_in_valid(dval[0]),
        .phr_psdu_in_ready(rdy[0]), .framing_encoding_out(out_a), .framing_encoding_out_valid(ov[0]),
        .frame_busy(busy[0]), .frame_error(ferr[0]));

    framing_encoding_param #(.SYMBOL_BITS(4), .PREAMBLE_BYTES(4), .SFD_VALUE(8'hA7), .APPEND_FCS(1'b0)) dut_b (
        .clk(clk), .reset_n(rstn), .phr_psdu_in(din[1]), .phr_psdu_in_valid(dval[1]),
        .phr_psdu_in_ready(rdy[1]), .framing_encoding_out(out_b), .framing_encoding_out_valid(ov[1]),
        .frame_busy(busy[1]), .frame_error(ferr[1]));

    framing_encoding_param #(.SYMBOL_BITS(1), .PREAMBLE_BYTES(4), .SFD_VALUE(8'hA7), .APPEND_FCS(1'b1)) dut_c (
        .clk(clk), .reset_n(rstn), .phr_psdu_in(din[2]), .phr_psdu_in_valid(dval[2]),
        .phr_psdu_in_ready(rdy[2]), .framing_encoding_out(out_c), .framing_encoding_out_valid(ov[2]),
        .frame_busy(busy[2]), .frame_error(ferr[2]));

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int act = -1;
    int frame_id = 0;
    logic [7:0] mdl_q [$];
    logic [7:0] src_q [$];
    logic [7:0] up_q  [$];

    int seen_id, idx;
    int run [3];
    int last_run [3];
    int run_start [3];
    int err_cnt [3];
    int err_cyc [3];
    bit post_err [3];
    bit rdy_post_err [3];

    int acc_cnt, acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint got, input longint want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    // Textbook CRC: remainder of M(x)*x^16 / G, message bits in transmit order; result packed by transmit time.
    function automatic logic [15:0] crc_model();
        logic [15:0] rem;
        logic [15:0] sent;
        bit fb;
        rem = 16'h0000;
        foreach (up_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb  = up_q[i][b] ^ rem[15];
                rem = {rem[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        for (int t = 0; t < 16; t++) sent[t] = rem[15 - t];
        return sent;
    endfunction

    task automatic build_model(input int sb, input bit fcs, input logic [7:0] phr);
        logic [7:0] oct [$];
        bit bits [$];
        logic [15:0] f;
        logic [7:0] s;
        for (int i = 0; i < 4; i++) oct.push_back(8'h00);
        oct.push_back(8'hA7);
        oct.push_back(phr);
        foreach (up_q[i]) oct.push_back(up_q[i]);
        if (fcs) begin
            f = crc_model();
            oct.push_back(f[7:0]);
            oct.push_back(f[15:8]);
        end
        foreach (oct[i]) for (int b = 0; b < 8; b++) bits.push_back(oct[i][b]);
        mdl_q.delete();
        for (int j = 0; j < bits.size(); j += sb) begin
            s = 8'h00;
            for (int b = 0; b < sb; b++) s[b] = bits[j + b];
            mdl_q.push_back(s);
        end
    endtask

    task automatic drive(input int k, input int ncyc);
        bit xfer;
        acc_cnt = 0;
        acc_cyc = -1;
        for (int i = 0; i < ncyc; i++) begin
            dval[k] = (src_q.size() != 0);
            din[k]  = (src_q.size() != 0) ? src_q[0] : 8'h00;
            @(negedge clk);
            xfer = dval[k] && rdy[k];
            @(posedge clk);
            #1;
            if (xfer) begin
                if (acc_cnt == 0) acc_cyc = cyc;
                acc_cnt++;
                void'(src_q.pop_front());
            end
        end
        dval[k] = 1'b0;
        din[k]  = 8'h00;
    endtask

    // Compare process: every negedge, every instance.
    initial begin
        seen_id = 0;
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            run[k] = 0; last_run[k] = 0; run_start[k] = -1;
            err_cnt[k] = 0; err_cyc[k] = -1; post_err[k] = 0; rdy_post_err[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (frame_id != seen_id) begin
                seen_id = frame_id;
                idx = 0;
            end
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    if (run[k] == 0) run_start[k] = cyc;
                    run[k]++;
                    if (k == act && idx < mdl_q.size()) begin
                        chk(dout[k] == mdl_q[idx], "symbol", dout[k], mdl_q[idx]);
                        idx++;
                    end else begin
                        chk(1'b0, "unexpected_symbol", k, act);
                    end
                end else begin
                    chk(dout[k] == 8'h00, "idle_out_zero", dout[k], 0);
                    if (run[k] != 0) begin
                        last_run[k] = run[k];
                        run[k] = 0;
                    end
                end
                if (post_err[k]) begin
                    rdy_post_err[k] = rdy[k];
                    post_err[k] = 0;
                end
                if (ferr[k]) begin
                    err_cnt[k]++;
                    err_cyc[k] = cyc;
                    post_err[k] = 1;
                end
            end
        end
    end

    initial begin
        int e;
        logic [15:0] lit16;
        logic [3:0] v2_lit [18];
        v2_lit = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'hA,
                   4'h3, 4'h0, 4'h1, 4'h0, 4'h5, 4'h0, 4'h1, 4'h2};
        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din[k] = 8'h00;
            dval[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(rdy[k] == 1'b0, "reset_ready", rdy[k], 0);
            chk(ov[k] == 1'b0, "reset_out_valid", ov[k], 0);
            chk(busy[k] == 1'b0, "reset_busy", busy[k], 0);
            chk(ferr[k] == 1'b0, "reset_error", ferr[k], 0);
        end
        #2 rstn = 1'b1;
        #1 chk(rdy[0] == 1'b0, "ready_before_first_edge", rdy[0], 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk(rdy[k] == 1'b1, "ready_first_edge", rdy[k], 1);

        // V1: SYMBOL_BITS=1, back-to-back PSDU
        act = 0;
        up_q = '{8'h01, 8'h05, 8'h21};
        build_model(1, 1'b0, 8'h03);
        chk(mdl_q.size() == 72, "v1_model_len", mdl_q.size(), 72);
        lit16 = 16'h03A7;
        for (int t = 0; t < 16; t++) chk(mdl_q[32 + t][0] == lit16[t], "v1_model_sfd_phr_bit", mdl_q[32 + t], lit16[t]);
        frame_id++;
        src_q = '{8'h03, 8'h01, 8'h05, 8'h21};
        e = err_cnt[0];
        drive(0, 85);
        chk(idx == 72, "v1_symbols_seen", idx, 72);
        chk(last_run[0] == 72, "v1_contiguous", last_run[0], 72);
        chk(run_start[0] == acc_cyc, "v1_latency", run_start[0], acc_cyc);
        chk(acc_cnt == 4, "v1_accepted", acc_cnt, 4);
        chk(err_cnt[0] == e, "v1_no_error", err_cnt[0], e);

        // V2: same frame, SYMBOL_BITS=4
        act = 1;
        build_model(4, 1'b0, 8'h03);
        chk(mdl_q.size() == 18, "v2_model_len", mdl_q.size(), 18);
        for (int i = 0; i < 18; i++) chk(mdl_q[i] == {4'h0, v2_lit[i]}, "v2_model_nibble", mdl_q[i], v2_lit[i]);
        frame_id++;
        src_q = '{8'h03, 8'h01, 8'h05, 8'h21};
        e = err_cnt[1];
        drive(1, 30);
        chk(idx == 18, "v2_symbols_seen", idx, 18);
        chk(last_run[1] == 18, "v2_contiguous", last_run[1], 18);
        chk(run_start[1] == acc_cyc, "v2_latency", run_start[1], acc_cyc);
        chk(acc_cnt == 4, "v2_accepted", acc_cnt, 4);
        chk(err_cnt[1] == e, "v2_no_error", err_cnt[1], e);

        // V3: underrun after first PSDU octet
        act = 0;
        build_model(1, 1'b0, 8'h03);
        frame_id++;
        src_q = '{8'h03, 8'h01};
        e = err_cnt[0];
        drive(0, 75);
        chk(idx == 56, "v3_symbols_seen", idx, 56);
        chk(last_run[0] == 56, "v3_run_len", last_run[0], 56);
        chk(err_cnt[0] == e + 1, "v3_error_pulses", err_cnt[0] - e, 1);
        chk(err_cyc[0] == run_start[0] + 56, "v3_error_cycle", err_cyc[0], run_start[0] + 56);
        chk(rdy_post_err[0] == 1'b1, "v3_ready_after", rdy_post_err[0], 1);
        chk(acc_cnt == 2, "v3_accepted", acc_cnt, 2);

        // V4: FCS appended, SYMBOL_BITS=1
        act = 2;
        up_q = '{8'h40, 8'h00};
        chk(crc_model() == 16'h4666, "v4_model_crc", crc_model(), 16'h4666);
        build_model(1, 1'b1, 8'h04);
        chk(mdl_q.size() == 80, "v4_model_len", mdl_q.size(), 80);
        frame_id++;
        src_q = '{8'h04, 8'h40, 8'h00};
        e = err_cnt[2];
        drive(2, 95);
        chk(idx == 80, "v4_symbols_seen", idx, 80);
        chk(last_run[2] == 80, "v4_contiguous", last_run[2], 80);
        chk(run_start[2] == acc_cyc, "v4_latency", run_start[2], acc_cyc);
        chk(acc_cnt == 3, "v4_accepted", acc_cnt, 3);
        chk(err_cnt[2] == e, "v4_no_error", err_cnt[2], e);

        // V5: FCS with L<2 is rejected
        act = 2;
        mdl_q.delete();
        frame_id++;
        src_q = '{8'h01};
        e = err_cnt[2];
        drive(2, 10);
        chk(idx == 0, "v5_no_symbols", idx, 0);
        chk(err_cnt[2] == e + 1, "v5_error_pulses", err_cnt[2] - e, 1);
        chk(err_cyc[2] == acc_cyc, "v5_error_cycle", err_cyc[2], acc_cyc);
        chk(busy[2] == 1'b0, "v5_idle", busy[2], 0);

        // V6: reset mid-PSDU, then a full frame
        act = 0;
        up_q = '{8'h01, 8'h05, 8'h21};
        build_model(1, 1'b0, 8'h03);
        frame_id++;
        src_q = '{8'h03, 8'h01, 8'h05, 8'h21};
        e = err_cnt[0];
        drive(0, 52);
        src_q.delete();
        #2 rstn = 1'b0;
        #1;
        chk(ov[0] == 1'b0, "v6_async_out_valid", ov[0], 0);
        chk(dout[0] == 8'h00, "v6_async_out", dout[0], 0);
        chk(busy[0] == 1'b0, "v6_async_busy", busy[0], 0);
        chk(rdy[0] == 1'b0, "v6_async_ready", rdy[0], 0);
        #19 rstn = 1'b1;
        #1 chk(rdy[0] == 1'b0, "v6_ready_before_edge", rdy[0], 0);
        @(posedge clk);
        #1 chk(rdy[0] == 1'b1, "v6_ready_first_edge", rdy[0], 1);
        frame_id++;
        src_q = '{8'h03, 8'h01, 8'h05, 8'h21};
        drive(0, 85);
        chk(idx == 72, "v6_symbols_seen", idx, 72);
        chk(last_run[0] == 72, "v6_contiguous", last_run[0], 72);
        chk(run_start[0] == acc_cyc, "v6_latency", run_start[0], acc_cyc);
        chk(acc_cnt == 4, "v6_accepted", acc_cnt, 4);
        chk(err_cnt[0] == e, "v6_no_error", err_cnt[0], e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
